// File: rtl/seq_and_checker.sv
// Concurrent multi-channel sequence checker: per-channel high-run windows ANDed into one pass/fail verdict.
// Optional statistics counters (pass/fail/drop) are enabled by defining SEQ_CHK_STATS_EN.
module seq_and_checker #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 4,
  parameter int unsigned SW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NCH-1:0]    sig,
  input  logic [NCH*CW-1:0] cfg_dly,
  input  logic [NCH*CW-1:0] cfg_len,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [NCH-1:0]    fail_mask
`ifdef SEQ_CHK_STATS_EN
  ,
  output logic [SW-1:0]     pass_cnt,
  output logic [SW-1:0]     fail_cnt,
  output logic [SW-1:0]     drop_cnt
`endif
);

  localparam int unsigned EW = CW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (NCH < 1 || NCH > 16 || CW < 1 || SW < 1) begin : g_bad_param
    $error("seq_and_checker: parameter out of range");
  end

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_start_q;
  logic [EW-1:0]     r_e;
  logic [EW-1:0]     w_e_nxt;
  logic [NCH*CW-1:0] r_dly;
  logic [NCH*CW-1:0] r_len;

  logic              w_rose;
  logic              w_trig;
  logic [NCH*CW-1:0] w_dly_sel;
  logic [NCH*CW-1:0] w_len_sel;
  logic [EW-1:0]     w_e_cur;
  logic [EW-1:0]     w_end_max;
  logic [NCH-1:0]    w_viol;
  logic              w_last;
  logic              w_busy_nxt;
  logic              w_pass_nxt;
  logic              w_fail_nxt;
  logic [NCH-1:0]    w_mask_nxt;

  // At the trigger edge the live config and e=0 are evaluated; afterwards the latched copy.
  assign w_rose    = start & ~r_start_q;
  assign w_trig    = (r_state == IDLE) & w_rose;
  assign w_dly_sel = (r_state == IDLE) ? cfg_dly : r_dly;
  assign w_len_sel = (r_state == IDLE) ? cfg_len : r_len;
  assign w_e_cur   = (r_state == IDLE) ? '0 : r_e;
  assign w_last    = (EW'(w_e_cur + EW'(1)) >= w_end_max);

  always_comb begin : window_check
    logic [EW-1:0] lo;
    logic [EW-1:0] hi;
    lo        = '0;
    hi        = '0;
    w_end_max = '0;
    w_viol    = '0;
    for (int i = 0; i < NCH; i++) begin
      lo = EW'(w_dly_sel[i*CW +: CW]);
      hi = EW'(lo + EW'(w_len_sel[i*CW +: CW]));
      if (hi > w_end_max) w_end_max = hi;
      w_viol[i] = (lo <= w_e_cur) && (w_e_cur < hi) && !sig[i];
    end
  end

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_e_nxt     = r_e;
    w_pass_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    w_mask_nxt  = '0;
    w_busy_nxt  = (r_state == RUN) | (w_trig & (w_end_max > EW'(1)));
    if (w_trig || (r_state == RUN)) begin
      if (|w_viol) begin
        w_fail_nxt  = 1'b1;
        w_mask_nxt  = w_viol;
        w_state_nxt = IDLE;
      end else if (w_last) begin
        w_pass_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = RUN;
        w_e_nxt     = EW'(w_e_cur + EW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_e       <= '0;
      r_dly     <= '0;
      r_len     <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_mask <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      r_e       <= w_e_nxt;
      if (w_trig) begin
        r_dly <= cfg_dly;
        r_len <= cfg_len;
      end
      busy      <= w_busy_nxt;
      pass      <= w_pass_nxt;
      fail      <= w_fail_nxt;
      fail_mask <= w_mask_nxt;
    end
  end

`ifdef SEQ_CHK_STATS_EN
  logic w_drop;
  assign w_drop = w_rose & (r_state == RUN);

  // Saturating event counters.
  always_ff @(posedge clk) begin : stats_regs
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (w_pass_nxt && (pass_cnt != '1)) pass_cnt <= SW'(pass_cnt + SW'(1));
      if (w_fail_nxt && (fail_cnt != '1)) fail_cnt <= SW'(fail_cnt + SW'(1));
      if (w_drop && (drop_cnt != '1))     drop_cnt <= SW'(drop_cnt + SW'(1));
    end
  end
`endif

endmodule

// File: tb/tb_seq_and_checker.sv
// Scoreboard bench for seq_and_checker: stimulus pushes expected verdicts, a negedge monitor pops and compares.
module tb_seq_and_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] sig;
  logic [7:0] cfg_dly;
  logic [7:0] cfg_len;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [1:0] fail_mask;
`ifdef SEQ_CHK_STATS_EN
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [15:0] drop_cnt;
`endif

  seq_and_checker #(.NCH(2), .CW(4), .SW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sig       (sig),
    .cfg_dly   (cfg_dly),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .fail_mask (fail_mask)
`ifdef SEQ_CHK_STATS_EN
    ,
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  typedef struct {
    int         cyc;
    bit         is_pass;
    logic [1:0] mask;
  } exp_t;

  exp_t q[$];
  bit   exp_busy [int];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input bit p, input logic [1:0] m);
    exp_t e;
    e.cyc     = c;
    e.is_pass = p;
    e.mask    = m;
    q.push_back(e);
  endtask

  // Inputs applied here belong to cycle 'cyc' and are sampled at the edge that ends it.
  task automatic tick(input logic st, input logic [1:0] s);
    @(posedge clk);
    #1;
    start = st;
    sig   = s;
  endtask

  task automatic set_cfg(input logic [3:0] d0, input logic [3:0] l0,
                         input logic [3:0] d1, input logic [3:0] l1);
    cfg_dly = {d1, d0};
    cfg_len = {l1, l0};
  endtask

  // Monitor: verdict pulses are matched in order against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (pass && fail) chk("pass_fail_exclusive", 32'd1, 32'd0);
    if (exp_busy.exists(cyc)) chk("busy", 32'(busy), 32'(exp_busy[cyc]));
    if (pass || fail) begin
      if (q.size() == 0) begin
        chk("unexpected_verdict", {30'd0, pass, fail}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("verdict_cycle", cyc, e.cyc);
        chk("verdict_is_pass", 32'(pass), 32'(e.is_pass));
        chk("fail_mask", 32'(fail_mask), e.is_pass ? 32'd0 : 32'(e.mask));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sig   = 2'b00;
    set_cfg(4'd0, 4'd2, 4'd1, 4'd2);
    tick(0, 2'b00);
    tick(0, 2'b00);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_fail", 32'(fail), 32'd0);
    chk("reset_mask", 32'(fail_mask), 32'd0);
    tick(0, 2'b00);
    rst_n = 1'b1;
    tick(0, 2'b00);

    // Both windows satisfied: END=3, pass three cycles after trigger.
    tick(1, 2'b01);
    t = cyc;
    exp_busy[t] = 0; exp_busy[t+1] = 1; exp_busy[t+2] = 1; exp_busy[t+3] = 1; exp_busy[t+4] = 0;
    push_exp(t + 3, 1, 2'b00);
    tick(0, 2'b11);
    tick(0, 2'b10);
    tick(0, 2'b00);
    tick(0, 2'b00);
    tick(0, 2'b00);

    // ch1 drops on its last sample; config changed mid-attempt must be ignored.
    tick(1, 2'b01);
    t = cyc;
    push_exp(t + 3, 0, 2'b10);
    tick(0, 2'b11);
    set_cfg(4'd0, 4'd0, 4'd0, 4'd0);
    tick(0, 2'b00);
    tick(0, 2'b00);
    tick(0, 2'b00);

    // Early fail at e=0 on ch0; later samples ignored.
    set_cfg(4'd0, 4'd2, 4'd1, 4'd2);
    tick(0, 2'b00);
    tick(1, 2'b00);
    t = cyc;
    push_exp(t + 1, 0, 2'b01);
    exp_busy[t+2] = 0;
    tick(0, 2'b11);
    tick(0, 2'b11);
    tick(0, 2'b00);

    // All lengths zero: immediate pass, busy never rises.
    set_cfg(4'd0, 4'd0, 4'd0, 4'd0);
    tick(0, 2'b00);
    tick(1, 2'b00);
    t = cyc;
    push_exp(t + 1, 1, 2'b00);
    exp_busy[t+1] = 0; exp_busy[t+2] = 0;
    tick(0, 2'b00);
    tick(0, 2'b00);

    // END=1: decided at trigger edge, pass then fail.
    set_cfg(4'd0, 4'd1, 4'd0, 4'd0);
    tick(1, 2'b01);
    t = cyc;
    push_exp(t + 1, 1, 2'b00);
    exp_busy[t+1] = 0;
    tick(0, 2'b00);
    tick(0, 2'b00);
    tick(1, 2'b10);
    t = cyc;
    push_exp(t + 1, 0, 2'b01);
    exp_busy[t+1] = 0;
    tick(0, 2'b00);
    tick(0, 2'b00);

    // Overlap: rise at t0+2 dropped, rise in verdict cycle starts a new attempt.
    set_cfg(4'd0, 4'd4, 4'd2, 4'd2);
    tick(0, 2'b00);
    tick(1, 2'b11);
    t = cyc;
    push_exp(t + 4, 1, 2'b00);
    push_exp(t + 8, 1, 2'b00);
    exp_busy[t+3] = 1; exp_busy[t+4] = 1; exp_busy[t+5] = 1; exp_busy[t+8] = 1; exp_busy[t+9] = 0;
    tick(0, 2'b11);
    tick(1, 2'b11);
    tick(0, 2'b11);
    tick(1, 2'b11);
    tick(0, 2'b11);
    tick(0, 2'b11);
    tick(0, 2'b11);
    tick(0, 2'b00);
    tick(0, 2'b00);
    tick(0, 2'b00);
`ifdef SEQ_CHK_STATS_EN
    @(negedge clk);
    chk("pass_cnt", 32'(pass_cnt), 32'd5);
    chk("fail_cnt", 32'(fail_cnt), 32'd3);
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Reset mid-attempt with violating input: no verdict; start high right after reset is a rise.
    set_cfg(4'd0, 4'd2, 4'd1, 4'd2);
    tick(0, 2'b00);
    tick(1, 2'b01);
    t = cyc;
    exp_busy[t+1] = 1; exp_busy[t+2] = 0;
    tick(0, 2'b00);
    rst_n = 1'b0;
    tick(1, 2'b01);
    rst_n = 1'b1;
    t = cyc;
    push_exp(t + 3, 1, 2'b00);
    exp_busy[t+3] = 1;
    tick(0, 2'b11);
    tick(0, 2'b10);
    tick(0, 2'b00);
    tick(0, 2'b00);
    tick(0, 2'b00);
`ifdef SEQ_CHK_STATS_EN
    @(negedge clk);
    chk("pass_cnt_after_reset", 32'(pass_cnt), 32'd1);
    chk("fail_cnt_after_reset", 32'(fail_cnt), 32'd0);
    chk("drop_cnt_after_reset", 32'(drop_cnt), 32'd0);
`endif
    tick(0, 2'b00);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_and_checker.md
Name: seq_and_checker

Overview:
- Synthesizable, run-time-configurable concurrent sequence checker for NCH channels.
- On each rising edge of start, checks that every channel's input is high for cfg_len consecutive cycles, beginning cfg_dly cycles after the trigger.
- Overall result is the AND of all channel sequences.
- Issues one pass or fail verdict per attempt, for use as an on-chip protocol monitor beside handshake datapaths.

Parameters:
- NCH, 2: number of checked channels (1..16).
- CW, 4: width of each per-channel delay/length field; max delay and length are 2^CW-1.
- SW, 16: width of statistics counters (only used with SEQ_CHK_STATS_EN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  trigger; an attempt launches on a sampled 0->1 transition
- sig  input  NCH  channel signals; bit i checked against channel i window
- cfg_dly  input  NCH*CW  per-channel start offset; field i = bits [i*CW +: CW]
- cfg_len  input  NCH*CW  per-channel required high run length; same packing
- busy  output  1  attempt in progress
- pass  output  1  one-cycle pulse: attempt succeeded
- fail  output  1  one-cycle pulse: attempt failed
- fail_mask  output  NCH  channels that violated; valid while fail=1, else 0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - busy, pass, fail, fail_mask are 0.
  - start_q (previous sample of start) is 0.
  - FSM goes to IDLE.
  - Reset mid-attempt abandons the attempt silently, with no verdict.
- Rose detection:
  - rose = start & ~start_q, evaluated on sampled values.
  - start high in the first cycle after reset counts as rose.
- Trigger cycle t0 is the edge where rose=1 in IDLE. At t0:
  - cfg_dly and cfg_len are latched; later config changes do not affect this attempt.
  - Elapsed counter e is cleared to 0.
  - end_i = dly_i + len_i, computed in CW+1 bits. END = max over i of end_i.
- Channel window: channel i is checked at elapsed e (e=0 at t0 itself) when dly_i <= e < end_i.
  - Channel i violates if sig[i]=0 at any checked e.
  - len_i=0 makes the channel vacuously true.
- FSM states: IDLE and RUN.
  - IDLE -> RUN at t0 when END > 1. Channel checks at e=0 happen in the same edge.
  - If END <= 1, the attempt completes at t0: no RUN state, busy never asserts, verdict appears at t0+1.
  - RUN: e increments each cycle and windows are checked every cycle.
- Verdicts:
  - Fail is early: at the first e with any violation, fail=1 and fail_mask = all channels violating at that e, in the following cycle. Then return to IDLE.
  - Pass: if no violation through e = END-1, pass=1 in the following cycle. Then return to IDLE.
  - Verdict latency is 1 cycle after the deciding sample.
  - pass and fail are never both 1.
- busy is 1 from t0+1 through the cycle in which pass or fail is asserted. Example: END=3 gives busy high for 3 cycles.
- Overlap:
  - rose while busy=1 is dropped; no second attempt starts.
  - rose in the same cycle that a verdict pulses is accepted, and a new attempt starts (back-to-back).
- Counters in e and END saturate cleanly; no wrap is possible because e never exceeds 2^(CW+1)-1.

Optional Feature:
- Macro: SEQ_CHK_STATS_EN.
- When defined, adds outputs pass_cnt[SW], fail_cnt[SW], drop_cnt[SW]:
  - Each counts pass pulses, fail pulses, and dropped overlapping rises respectively.
  - Each saturates at 2^SW-1.
  - All clear on reset.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- NCH=2, ch0 dly=0 len=2, ch1 dly=1 len=2. start rises at cycle 2; sig0 high cycles 2-3; sig1 high cycles 3-4 -> busy high 3-5, pass=1 at cycle 5, fail never asserts.
- Same config, sig1 low at cycle 4 -> fail=1 at cycle 5 with fail_mask=2'b10, pass never asserts.
- Same config, sig0 low at cycle 2 and sig1 low at cycle 3 -> fail at cycle 3, fail_mask=2'b01. Early fail: later samples are ignored.
- All cfg_len=0, single start rise -> pass at t0+1, busy stays 0.
- start toggles high again at t0+2 during a 4-cycle attempt, then again in the exact verdict cycle -> first rise dropped (drop_cnt=1 with SEQ_CHK_STATS_EN); second rise launches a new attempt.
- rst_n=0 at t0+1 of an attempt with violating inputs -> no pass/fail pulse, busy=0 next cycle; a fresh rise afterwards yields a normal verdict.
